map_load_controller: RTL and testbench
======================================

# map_load_controller

Sequences loading a new puzzle into the game board. On a `start` pulse it latches the requested difficulty and drives it to the map selector. It waits for the selector's registered outputs to settle, then snapshots the chosen solution map and visibility vectors. It streams all 81 cells to the board-memory write port under a ready/valid handshake, finishing with a one-cycle `done` pulse to the game FSM.

## Interface
- `SETTLE_CYCLES`, default 2: cycles spent in SELECT after the difficulty is driven, before capture. Legal range is 1–15.
- `NUM_CELLS`, default 81: number of cells streamed. The cell index width is 7 bits.
- `clk` in, 1 bit: clock.
- `reset` in, 1 bit: asynchronous, active-high.
- `start` in, 1 bit: load request. Sampled only in IDLE.
- `difficulty_in` in, 1 bit: requested difficulty (0 = easy, 1 = hard). Sampled with `start`.
- `sel_difficulty` out, 1 bit: difficulty driven to the map selector. Holds the latched value.
- `selected_map` in, 324 bits: solution; cell i digit is `[4i+:4]`.
- `selected_visibility` in, 162 bits: cell i flags are `[2i+:2]`; bit 2i = cell is given/visible.
- `wr_valid` out, 1 bit: a board write is presented.
- `wr_ready` in, 1 bit: board accepts the write.
- `wr_addr` out, 7 bits: cell index 0..80.
- `wr_value` out, 4 bits: digit written.
- `wr_flags` out, 2 bits: visibility flags for the cell.
- `busy` out, 1 bit: high in every state except IDLE.
- `done` out, 1 bit: one-cycle pulse at load completion.

## Operation
- **States:** IDLE, SELECT, CAPTURE, STREAM, DONE.
- **IDLE:**
  - `start`=1 latches `difficulty_in` into `sel_difficulty`, clears the settle counter, and moves to SELECT.
  - `start`=0 stays in IDLE.
- **SELECT:** counts SETTLE_CYCLES cycles, then moves to CAPTURE. This covers the selector's one-cycle output register plus margin.
- **CAPTURE:** for one cycle, copies `selected_map` and `selected_visibility` into internal shadow registers, zeroes the cell index, and moves to STREAM. Later changes on the selector inputs (its random index keeps running) do not affect the load.
- **STREAM:**
  - `wr_valid`=1; `wr_addr`=index; `wr_value`/`wr_flags` come from the shadow registers at that index.
  - A transfer occurs on a cycle with `wr_valid && wr_ready`. The index then increments.
  - A transfer at index NUM_CELLS-1 moves to DONE instead of incrementing.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` while `busy` is ignored and not queued.
- `sel_difficulty` is updated only on an accepted `start` and holds until the next accepted `start`.
- **Reset, asserted anytime (including mid-STREAM):** state returns to IDLE and the load is abandoned. Partial board contents are not cleaned up.

## Timing
- **Reset values:** state IDLE; `sel_difficulty`=0, `wr_valid`=0, `wr_addr`=0, `wr_value`=0, `wr_flags`=0, `busy`=0, `done`=0; shadow registers are all 0.
- **Outputs:** `wr_addr`, `wr_value`, `wr_flags` and `wr_valid` are registered, or decoded directly from registered state and index. There is no combinational path from `wr_ready` to any output.
- **Handshake hold:** while `wr_valid`=1 and `wr_ready`=0, `wr_addr`/`wr_value`/`wr_flags` hold stable.
- **Latency, with `start` accepted at edge 0 and `wr_ready` tied high (defaults):**
  - SELECT covers cycles 1–2.
  - CAPTURE is cycle 3.
  - STREAM covers cycles 4–84, one write per cycle.
  - `done` is high in cycle 85.
  - `busy` is high in cycles 1–85.
- **General latency:** start to `done` = SETTLE_CYCLES + 2 + NUM_CELLS + (number of stall cycles).
- `wr_valid` drops in the cycle after the last transfer.

## Configuration
- **Macro:** `MAP_LOAD_MASK_HIDDEN_EN`.
- **Defined:** for cells with flag bit 0 = 0 (hidden), `wr_value` is forced to 4'd0. The player sees an empty cell, and the solution digit is not exported.
- **Undefined:** `wr_value` always carries the solution digit. The board stores the solution for checking, and `wr_flags` alone controls display.
- `wr_flags` is always passed unmodified.

## Test plan
- **Reset / idle:** reset with `start` held low → all outputs 0, `busy`=0 indefinitely.
- **Full easy load:**
  - Stimulus: `difficulty_in`=0, `start` pulse, `wr_ready`=1, map cell i digit = (i mod 9)+1, visibility = alternating 2'b01/2'b00.
  - Required: 81 writes with addr 0..80 in order, correct digits/flags, `done` in cycle 85 after start, `sel_difficulty`=0.
  - With `MAP_LOAD_MASK_HIDDEN_EN` defined: odd cells are written as value 0.
- **Backpressure:**
  - Stimulus: hard load, `wr_ready` low for 3 cycles at addr 40 and low for 1 cycle at addr 80.
  - Required: addr/value held during stalls, no duplicated or skipped address, `done` at cycle 89.
- **Input change after capture:** change `selected_map` to all-0xF after CAPTURE → streamed data still matches the captured snapshot.
- **Start while busy:**
  - Stimulus: pulse `start` with `difficulty_in`=1 during STREAM of an easy load.
  - Required: ignored; `sel_difficulty` stays 0; only one `done`.
- **Mid-load reset:** assert `reset` at addr 30 → next cycle outputs are at reset values. A new `start` then restarts the load from addr 0.

Source files
------------

// File: rtl/map_load_controller.sv
// ============================================================================
// map_load_controller : latches difficulty, waits for the map selector, snapshots
// the chosen puzzle and streams 81 cells to board memory over a ready/valid port.
// Optional: MAP_LOAD_MASK_HIDDEN_EN zeroes the digit written for hidden cells.
// Rev 1.0
// ============================================================================
`default_nettype none

module map_load_controller #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_CELLS     = 81
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     difficulty_in,
   output logic                     sel_difficulty,
   input  logic [4*NUM_CELLS-1:0]   selected_map,
   input  logic [2*NUM_CELLS-1:0]   selected_visibility,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [6:0]               wr_addr,
   output logic [3:0]               wr_value,
   output logic [1:0]               wr_flags,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      CAPTURE = 3'd2,
      STREAM  = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [6:0] LAST_CELL   = 7'(NUM_CELLS - 1);

   state_t                   state;
   state_t                   state_next;
   logic [3:0]               settle_cnt;
   logic [6:0]               idx;
   logic [4*NUM_CELLS-1:0]   shadow_map;
   logic [2*NUM_CELLS-1:0]   shadow_vis;
   logic [3:0]               cell_digit;
   logic [1:0]               cell_flags;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers; the snapshot isolates the load from the free-running selector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_difficulty <= 1'b0;
         settle_cnt     <= 4'd0;
         idx            <= 7'd0;
         shadow_map     <= '0;
         shadow_vis     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sel_difficulty <= difficulty_in;
                  settle_cnt     <= 4'd0;
               end
            end
            SELECT: begin
               settle_cnt <= settle_cnt + 4'd1;
            end
            CAPTURE: begin
               shadow_map <= selected_map;
               shadow_vis <= selected_visibility;
               idx        <= 7'd0;
            end
            STREAM: begin
               if (wr_ready && (idx != LAST_CELL)) begin
                  idx <= idx + 7'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      cell_digit = shadow_map[{idx, 2'b00} +: 4];
      cell_flags = shadow_vis[{idx, 1'b0} +: 2];
   end

   always_comb begin
      state_next = state;
      wr_valid   = 1'b0;
      wr_addr    = 7'd0;
      wr_value   = 4'd0;
      wr_flags   = 2'b00;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = SELECT;
            end
         end
         SELECT: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            state_next = STREAM;
         end
         STREAM: begin
            wr_valid = 1'b1;
            wr_addr  = idx;
            wr_flags = cell_flags;
`ifdef MAP_LOAD_MASK_HIDDEN_EN
            wr_value = cell_flags[0] ? cell_digit : 4'd0;
`else
            wr_value = cell_digit;
`endif
            // Outputs above depend only on state/idx; wr_ready only steers the next state.
            if (wr_ready && (idx == LAST_CELL)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_map_load_controller.sv
// ============================================================================
// tb_map_load_controller : directed self-checking bench for map_load_controller.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_map_load_controller;

   localparam int N = 81;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           difficulty_in = 1'b0;
   logic           wr_ready = 1'b1;
   logic [4*N-1:0] selected_map = '0;
   logic [2*N-1:0] selected_visibility = '0;
   logic           sel_difficulty;
   logic           wr_valid;
   logic [6:0]     wr_addr;
   logic [3:0]     wr_value;
   logic [1:0]     wr_flags;
   logic           busy;
   logic           done;

   logic [4*N-1:0] snap_map;
   logic [2*N-1:0] snap_vis;

   int n_cmp = 0;
   int n_bad = 0;

   map_load_controller #(
      .SETTLE_CYCLES(2),
      .NUM_CELLS(N)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .difficulty_in       (difficulty_in),
      .sel_difficulty      (sel_difficulty),
      .selected_map        (selected_map),
      .selected_visibility (selected_visibility),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_addr             (wr_addr),
      .wr_value            (wr_value),
      .wr_flags            (wr_flags),
      .busy                (busy),
      .done                (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Easy: digit (i mod 9)+1, flags 01/00 alternating. Hard: scrambled digits, mixed flags.
   task automatic set_pattern(input bit hard);
      for (int i = 0; i < N; i++) begin
         int d;
         d = hard ? ((i * 7) % 9) + 1 : (i % 9) + 1;
         selected_map[4*i +: 4] = 4'(d);
         if (hard) selected_visibility[2*i +: 2] = (i % 3 == 0) ? 2'b01 : 2'b10;
         else      selected_visibility[2*i +: 2] = (i % 2 == 0) ? 2'b01 : 2'b00;
      end
      snap_map = selected_map;
      snap_vis = selected_visibility;
   endtask

   function automatic logic [3:0] exp_value(input int i);
      logic [3:0] d;
      d = snap_map[4*i +: 4];
`ifdef MAP_LOAD_MASK_HIDDEN_EN
      if (!snap_vis[2*i]) d = 4'd0;
`endif
      return d;
   endfunction

   // Issues a start and follows the load cycle by cycle (cycle 1 = first after the accepting edge).
   task automatic run_load(input bit diff, input int s40, input int s80, input int exp_done,
                           input bit poke_busy, input bit clobber);
      int exp_addr, dones, done_cyc, n40, n80;
      exp_addr = 0; dones = 0; done_cyc = -1; n40 = 0; n80 = 0;
      @(negedge clk);
      start = 1'b1; difficulty_in = diff; wr_ready = 1'b1;
      for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 1) begin
            check("busy_c1", busy, 1);
            check("seldiff_c1", sel_difficulty, diff);
         end
         if (cyc == 3) check("valid_capture", wr_valid, 0);
         if (poke_busy && cyc == 20) begin
            start = 1'b1; difficulty_in = ~diff;
         end
         if (clobber && cyc == 4) selected_map = '1;
         if (wr_valid) begin
            check("wr_addr", wr_addr, exp_addr);
            if (exp_addr < N) begin
               check("wr_value", wr_value, exp_value(exp_addr));
               check("wr_flags", wr_flags, snap_vis[2*exp_addr +: 2]);
            end
            wr_ready = 1'b1;
            if (exp_addr == 40 && n40 < s40) begin
               wr_ready = 1'b0; n40++;
            end else if (exp_addr == N-1 && n80 < s80) begin
               wr_ready = 1'b0; n80++;
            end
            if (wr_ready) exp_addr++;
         end else begin
            wr_ready = 1'b1;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1);
            check("valid_at_done", wr_valid, 0);
         end
      end
      wr_ready = 1'b1;
      check("write_count", exp_addr, N);
      check("done_cycle", done_cyc, exp_done);
      check("done_count", dones, 1);
      check("busy_after", busy, 0);
      check("valid_after", wr_valid, 0);
      check("seldiff_hold", sel_difficulty, diff);
      selected_map = snap_map;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seldiff"}, sel_difficulty, 0);
      check({tag, "_valid"}, wr_valid, 0);
      check({tag, "_addr"}, wr_addr, 0);
      check({tag, "_value"}, wr_value, 0);
      check({tag, "_flags"}, wr_flags, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      bit found;
      // Reset and idle with start low
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_reset_outputs("idle");

      // Full easy load, backpressured hard load, snapshot isolation, start while busy
      set_pattern(1'b0);
      run_load(1'b0, 0, 0, 85, 1'b0, 1'b0);
      set_pattern(1'b1);
      run_load(1'b1, 3, 1, 89, 1'b0, 1'b0);
      run_load(1'b1, 0, 0, 85, 1'b0, 1'b1);
      set_pattern(1'b0);
      run_load(1'b0, 0, 0, 85, 1'b1, 1'b0);

      // Mid-load reset at addr 30 during a hard load, then a clean restart
      set_pattern(1'b1);
      found = 1'b0;
      @(negedge clk);
      start = 1'b1; difficulty_in = 1'b1;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (wr_valid && wr_addr == 7'd30) found = 1'b1;
      end
      check("reach_addr30", found, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      set_pattern(1'b0);
      run_load(1'b0, 0, 0, 85, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
